// File: rtl/cp0_move_unit.sv
`default_nettype none
// ============================================================================
// Module   : cp0_move_unit
// Purpose  : CP0 system-control registers (BadVAddr, Count, Compare, Status,
//            Cause, EPC) serving MTC0/MFC0, exception push, RFE pop, timer
//            compare and interrupt request generation.
// Revision : 1.0 - initial release
// ============================================================================
module cp0_move_unit #(
    parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF,
    parameter int          NUM_EXT_INT   = 5
) (
    input  logic                   Phi1,
    input  logic                   Reset_s1,
    input  logic [31:0]            Cp0Bus_s2m,
    input  logic                   MvToCop0_s2m,
    input  logic                   MvFromCop0_s2m,
    input  logic [4:0]             Cp0RegNum_s2m,
    output logic [31:0]            Cp0BusOut_v2m,
    output logic                   cp0BusDrv_s2m,
    input  logic                   Exception_s2m,
    input  logic [4:0]             ExcCode_s2m,
    input  logic [31:0]            ExcPC_s2m,
    input  logic                   ExcBD_s2m,
    input  logic [31:0]            BadAddr_s2m,
    input  logic                   Rfe_s2m,
    input  logic [NUM_EXT_INT-1:0] ExtInt_s1,
    output logic                   IntReq_s1,
    output logic                   KernelMode_s1
);

    localparam logic [4:0] c_REG_BADVADDR = 5'd8;
    localparam logic [4:0] c_REG_COUNT    = 5'd9;
    localparam logic [4:0] c_REG_COMPARE  = 5'd11;
    localparam logic [4:0] c_REG_STATUS   = 5'd12;
    localparam logic [4:0] c_REG_CAUSE    = 5'd13;
    localparam logic [4:0] c_REG_EPC      = 5'd14;

    logic [31:0] r_badVAddr, r_count, r_compare, r_epc;
    logic [5:0]  r_statusStk;
    logic [7:0]  r_statusIm;
    logic        r_causeBd, r_causeIp7;
    logic [4:0]  r_causeIpExt;
    logic [1:0]  r_causeIpSw;
    logic [4:0]  r_causeExcCode;
    logic [31:0] r_busOut;
    logic        r_busDrv, r_intReq;

    logic [4:0]  w_extInt;
    logic [31:0] w_status, w_cause, w_readData, w_countNext;
    logic        w_wr, w_wrCount, w_wrCompare, w_wrStatus, w_wrCause, w_wrEpc;
    logic        w_timerHit, w_excHasAddr, w_ip7Next, w_intReqNext;
    logic [5:0]  w_statusStkNext;
    logic [7:0]  w_statusImNext;
    logic [1:0]  w_ipSwNext;

    // External lines map onto IP2..IP6; lines beyond the field are unused.
    for (genvar i = 0; i < 5; i++) begin : g_extInt
        if (i < NUM_EXT_INT) begin : g_used
            assign w_extInt[i] = ExtInt_s1[i];
        end else begin : g_unused
            assign w_extInt[i] = 1'b0;
        end
    end

    assign w_status = {16'b0, r_statusIm, 2'b0, r_statusStk};
    assign w_cause  = {r_causeBd, 15'b0, r_causeIp7, r_causeIpExt, r_causeIpSw,
                       1'b0, r_causeExcCode, 2'b0};

    always_comb begin
        w_readData = 32'b0;
        case (Cp0RegNum_s2m)
            c_REG_BADVADDR: w_readData = r_badVAddr;
            c_REG_COUNT:    w_readData = r_count;
            c_REG_COMPARE:  w_readData = r_compare;
            c_REG_STATUS:   w_readData = w_status;
            c_REG_CAUSE:    w_readData = w_cause;
            c_REG_EPC:      w_readData = r_epc;
            default:        w_readData = 32'b0;
        endcase
    end

    // A committing exception swallows any MTC0 issued in the same cycle.
    assign w_wr         = MvToCop0_s2m & ~Exception_s2m;
    assign w_wrCount    = w_wr && (Cp0RegNum_s2m == c_REG_COUNT);
    assign w_wrCompare  = w_wr && (Cp0RegNum_s2m == c_REG_COMPARE);
    assign w_wrStatus   = w_wr && (Cp0RegNum_s2m == c_REG_STATUS);
    assign w_wrCause    = w_wr && (Cp0RegNum_s2m == c_REG_CAUSE);
    assign w_wrEpc      = w_wr && (Cp0RegNum_s2m == c_REG_EPC);
    assign w_countNext  = w_wrCount ? Cp0Bus_s2m : r_count + 32'd1;
    assign w_timerHit   = (w_countNext == r_compare);
    assign w_excHasAddr = (ExcCode_s2m >= 5'd1) && (ExcCode_s2m <= 5'd5);

    always_comb begin
        w_statusStkNext = r_statusStk;
        w_statusImNext  = r_statusIm;
        if (Exception_s2m) begin
            w_statusStkNext = {r_statusStk[3:0], 2'b00};
        end else if (w_wrStatus) begin
            w_statusStkNext = Cp0Bus_s2m[5:0];
            w_statusImNext  = Cp0Bus_s2m[15:8];
        end else if (Rfe_s2m) begin
            w_statusStkNext = {r_statusStk[5:4], r_statusStk[5:2]};
        end
    end

    assign w_ip7Next    = w_wrCompare ? 1'b0 : (w_timerHit | r_causeIp7);
    assign w_ipSwNext   = w_wrCause ? Cp0Bus_s2m[9:8] : r_causeIpSw;
    assign w_intReqNext = w_statusStkNext[0] &
                          (|({w_ip7Next, w_extInt, w_ipSwNext} & w_statusImNext));

    always_ff @(posedge Phi1) begin
        if (Reset_s1) begin
            r_badVAddr     <= 32'b0;
            r_count        <= 32'b0;
            r_compare      <= RESET_COMPARE;
            r_epc          <= 32'b0;
            r_statusStk    <= 6'b0;
            r_statusIm     <= 8'b0;
            r_causeBd      <= 1'b0;
            r_causeIp7     <= 1'b0;
            r_causeIpExt   <= 5'b0;
            r_causeIpSw    <= 2'b0;
            r_causeExcCode <= 5'b0;
            r_busOut       <= 32'b0;
            r_busDrv       <= 1'b0;
            r_intReq       <= 1'b0;
        end else begin
            r_count      <= w_countNext;
            r_statusStk  <= w_statusStkNext;
            r_statusIm   <= w_statusImNext;
            r_causeIp7   <= w_ip7Next;
            r_causeIpExt <= w_extInt;
            r_causeIpSw  <= w_ipSwNext;
            r_intReq     <= w_intReqNext;
            r_busDrv     <= MvFromCop0_s2m;
            if (MvFromCop0_s2m) begin
                r_busOut <= w_readData;
            end
            if (w_wrCompare) begin
                r_compare <= Cp0Bus_s2m;
            end
            if (Exception_s2m) begin
                r_epc          <= ExcPC_s2m;
                r_causeExcCode <= ExcCode_s2m;
                r_causeBd      <= ExcBD_s2m;
                if (w_excHasAddr) begin
                    r_badVAddr <= BadAddr_s2m;
                end
            end else if (w_wrEpc) begin
                r_epc <= Cp0Bus_s2m;
            end
        end
    end

    assign Cp0BusOut_v2m = r_busOut;
    assign cp0BusDrv_s2m = r_busDrv;
    assign IntReq_s1     = r_intReq;
    assign KernelMode_s1 = ~r_statusStk[1];

endmodule
`default_nettype wire

// File: tb/tb_cp0_move_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0_move_unit
// Purpose  : Directed vector table plus randomized traffic against a
//            register-level reference model of the CP0 move unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0_move_unit;

    logic        Phi1, Reset_s1;
    logic [31:0] Cp0Bus_s2m, Cp0BusOut_v2m, ExcPC_s2m, BadAddr_s2m;
    logic        MvToCop0_s2m, MvFromCop0_s2m, cp0BusDrv_s2m;
    logic [4:0]  Cp0RegNum_s2m, ExcCode_s2m, ExtInt_s1;
    logic        Exception_s2m, ExcBD_s2m, Rfe_s2m, IntReq_s1, KernelMode_s1;

    cp0_move_unit #(.RESET_COMPARE(32'hFFFF_FFFF), .NUM_EXT_INT(5)) dut (
        .Phi1(Phi1), .Reset_s1(Reset_s1), .Cp0Bus_s2m(Cp0Bus_s2m),
        .MvToCop0_s2m(MvToCop0_s2m), .MvFromCop0_s2m(MvFromCop0_s2m),
        .Cp0RegNum_s2m(Cp0RegNum_s2m), .Cp0BusOut_v2m(Cp0BusOut_v2m),
        .cp0BusDrv_s2m(cp0BusDrv_s2m), .Exception_s2m(Exception_s2m),
        .ExcCode_s2m(ExcCode_s2m), .ExcPC_s2m(ExcPC_s2m), .ExcBD_s2m(ExcBD_s2m),
        .BadAddr_s2m(BadAddr_s2m), .Rfe_s2m(Rfe_s2m), .ExtInt_s1(ExtInt_s1),
        .IntReq_s1(IntReq_s1), .KernelMode_s1(KernelMode_s1)
    );

    initial Phi1 = 1'b0;
    always #5 Phi1 = ~Phi1;

    typedef struct {
        logic rst, mtc, mfc;
        logic [4:0] rn;
        logic [31:0] data;
        logic exc;
        logic [4:0] code;
        logic [31:0] pc;
        logic bd;
        logic [31:0] bad;
        logic rfe;
        logic [4:0] ext;
        logic [31:0] expOut;
        logic expDrv, expInt, expKm;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: whole architectural registers as 32-bit words.
    logic [31:0] mBad, mCount, mCompare, mStatus, mCause, mEpc, mOut;
    logic        mDrv, mInt;

    function automatic vec_t mk(logic rst, logic mtc, logic mfc, logic [4:0] rn,
                                logic [31:0] data, logic exc, logic [4:0] code,
                                logic [31:0] pc, logic bd, logic [31:0] bad,
                                logic rfe, logic [4:0] ext, logic [31:0] expOut,
                                logic expDrv, logic expInt, logic expKm);
        vec_t v;
        v.rst = rst; v.mtc = mtc; v.mfc = mfc; v.rn = rn; v.data = data;
        v.exc = exc; v.code = code; v.pc = pc; v.bd = bd; v.bad = bad;
        v.rfe = rfe; v.ext = ext; v.expOut = expOut; v.expDrv = expDrv;
        v.expInt = expInt; v.expKm = expKm;
        return v;
    endfunction

    function automatic logic [31:0] modelRead(logic [4:0] rn);
        case (rn)
            5'd8:    return mBad;
            5'd9:    return mCount;
            5'd11:   return mCompare;
            5'd12:   return mStatus;
            5'd13:   return mCause;
            5'd14:   return mEpc;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(vec_t v);
        Reset_s1 = v.rst; MvToCop0_s2m = v.mtc; MvFromCop0_s2m = v.mfc;
        Cp0RegNum_s2m = v.rn; Cp0Bus_s2m = v.data; Exception_s2m = v.exc;
        ExcCode_s2m = v.code; ExcPC_s2m = v.pc; ExcBD_s2m = v.bd;
        BadAddr_s2m = v.bad; Rfe_s2m = v.rfe; ExtInt_s1 = v.ext;
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic modelStep();
        logic wr;
        logic [31:0] nCount, nCause, nStatus;
        if (Reset_s1) begin
            mBad = 0; mCount = 0; mCompare = 32'hFFFF_FFFF; mStatus = 0;
            mCause = 0; mEpc = 0; mOut = 0; mDrv = 0; mInt = 0;
            return;
        end
        wr = MvToCop0_s2m && !Exception_s2m;
        if (MvFromCop0_s2m) mOut = modelRead(Cp0RegNum_s2m);
        mDrv = MvFromCop0_s2m;
        nCount = (wr && Cp0RegNum_s2m == 9) ? Cp0Bus_s2m : mCount + 1;
        nCause = mCause;
        nCause[14:10] = ExtInt_s1;
        if (wr && Cp0RegNum_s2m == 11) nCause[15] = 1'b0;
        else if (nCount == mCompare)   nCause[15] = 1'b1;
        if (wr && Cp0RegNum_s2m == 13) nCause[9:8] = Cp0Bus_s2m[9:8];
        nStatus = mStatus;
        if (Exception_s2m) begin
            nStatus = (mStatus & 32'h0000_FF00) | ((mStatus << 2) & 32'h3F);
            mEpc = ExcPC_s2m;
            nCause[31] = ExcBD_s2m;
            nCause[6:2] = ExcCode_s2m;
            if (ExcCode_s2m >= 1 && ExcCode_s2m <= 5) mBad = BadAddr_s2m;
        end else if (wr && Cp0RegNum_s2m == 12) begin
            nStatus = Cp0Bus_s2m & 32'h0000_FF3F;
        end else if (Rfe_s2m) begin
            nStatus = (mStatus & 32'h0000_FF30) | ((mStatus >> 2) & 32'hF);
        end
        if (wr && Cp0RegNum_s2m == 11) mCompare = Cp0Bus_s2m;
        if (wr && Cp0RegNum_s2m == 14) mEpc = Cp0Bus_s2m;
        mCount = nCount; mCause = nCause; mStatus = nStatus;
        mInt = nStatus[0] && ((nCause[15:8] & nStatus[15:8]) != 0);
    endtask

    task automatic check(string name, logic [31:0] eOut, logic eDrv,
                         logic eInt, logic eKm);
        vectors++;
        if (Cp0BusOut_v2m !== eOut || cp0BusDrv_s2m !== eDrv ||
            IntReq_s1 !== eInt || KernelMode_s1 !== eKm) begin
            miscompares++;
            $display("FAIL %s t=%0t got out=%h drv=%b int=%b km=%b want out=%h drv=%b int=%b km=%b",
                     name, $time, Cp0BusOut_v2m, cp0BusDrv_s2m, IntReq_s1,
                     KernelMode_s1, eOut, eDrv, eInt, eKm);
        end
    endtask

    task automatic step(string name);
        modelStep();
        @(posedge Phi1);
        #1;
        check(name, mOut, mDrv, mInt, !mStatus[1]);
    endtask

    vec_t tbl[29];
    logic [4:0] regPick[10] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14,
                                5'd0, 5'd10, 5'd15, 5'd31};

    initial begin
        // rst mtc mfc rn data | exc code pc bd bad | rfe ext | out drv int km
        tbl[0]  = mk(1,0,0,0, 0, 0,0,0,0,0, 0,0, 32'h0, 0,0,1);
        tbl[1]  = mk(0,0,1,11,0, 0,0,0,0,0, 0,0, 32'hFFFF_FFFF, 1,0,1);
        tbl[2]  = mk(0,0,1,12,0, 0,0,0,0,0, 0,0, 32'h0, 1,0,1);
        tbl[3]  = mk(0,0,0,0, 0, 0,0,0,0,0, 0,0, 32'h0, 0,0,1);
        tbl[4]  = mk(0,1,1,12,32'hFFFF_FF3F, 0,0,0,0,0, 0,0, 32'h0, 1,0,0);
        tbl[5]  = mk(0,0,1,12,0, 0,0,0,0,0, 0,0, 32'h0000_FF3F, 1,0,0);
        tbl[6]  = mk(0,1,0,9, 32'hFFFF_FFFE, 0,0,0,0,0, 0,0, 32'h0000_FF3F, 0,0,0);
        tbl[7]  = mk(0,1,0,11,32'h1, 0,0,0,0,0, 0,0, 32'h0000_FF3F, 0,0,0);
        tbl[8]  = mk(0,0,1,9, 0, 0,0,0,0,0, 0,0, 32'hFFFF_FFFF, 1,0,0);
        tbl[9]  = mk(0,0,1,9, 0, 0,0,0,0,0, 0,0, 32'h0, 1,1,0);
        tbl[10] = mk(0,0,1,13,0, 0,0,0,0,0, 0,0, 32'h0000_8000, 1,1,0);
        tbl[11] = mk(0,1,0,11,32'h7FFF_FFFF, 0,0,0,0,0, 0,0, 32'h0000_8000, 0,0,0);
        tbl[12] = mk(0,1,0,12,32'h3, 0,0,0,0,0, 0,0, 32'h0000_8000, 0,0,0);
        tbl[13] = mk(0,0,0,0, 0, 1,4,32'h8000_0100,1,32'h1234_5673, 0,0, 32'h0000_8000, 0,0,1);
        tbl[14] = mk(0,0,1,12,0, 0,0,0,0,0, 0,0, 32'h0000_000C, 1,0,1);
        tbl[15] = mk(0,0,1,14,0, 0,0,0,0,0, 0,0, 32'h8000_0100, 1,0,1);
        tbl[16] = mk(0,0,1,8, 0, 0,0,0,0,0, 0,0, 32'h1234_5673, 1,0,1);
        tbl[17] = mk(0,0,1,13,0, 0,0,0,0,0, 0,0, 32'h8000_0010, 1,0,1);
        tbl[18] = mk(0,0,0,0, 0, 0,0,0,0,0, 1,0, 32'h8000_0010, 0,0,0);
        tbl[19] = mk(0,0,1,12,0, 0,0,0,0,0, 0,0, 32'h0000_0003, 1,0,0);
        tbl[20] = mk(0,1,0,14,32'hDEAD_BEEF, 1,8,32'h0040_0020,0,32'hAAAA_AAAA, 0,0, 32'h0000_0003, 0,0,1);
        tbl[21] = mk(0,0,1,14,0, 0,0,0,0,0, 0,0, 32'h0040_0020, 1,0,1);
        tbl[22] = mk(0,0,1,8, 0, 0,0,0,0,0, 0,0, 32'h1234_5673, 1,0,1);
        tbl[23] = mk(0,0,1,13,0, 0,0,0,0,0, 0,0, 32'h0000_0020, 1,0,1);
        tbl[24] = mk(0,1,0,12,32'h0400, 0,0,0,0,0, 0,1, 32'h0000_0020, 0,0,1);
        tbl[25] = mk(0,1,0,12,32'h0401, 0,0,0,0,0, 0,1, 32'h0000_0020, 0,1,1);
        tbl[26] = mk(0,0,1,13,0, 0,0,0,0,0, 0,1, 32'h0000_0420, 1,1,1);
        tbl[27] = mk(1,0,1,12,0, 0,0,0,0,0, 0,1, 32'h0, 0,0,1);
        tbl[28] = mk(0,0,0,0, 0, 0,0,0,0,0, 0,0, 32'h0, 0,0,1);

        drive(tbl[0]);
        mBad = 0; mCount = 0; mCompare = 0; mStatus = 0; mCause = 0;
        mEpc = 0; mOut = 0; mDrv = 0; mInt = 0;
        #2;
        for (int i = 0; i < 29; i++) begin
            drive(tbl[i]);
            step($sformatf("model_row%0d", i));
            check($sformatf("table_row%0d", i), tbl[i].expOut, tbl[i].expDrv,
                  tbl[i].expInt, tbl[i].expKm);
        end

        for (int n = 0; n < 4000; n++) begin
            vec_t v;
            v.rst  = ($urandom_range(0, 99) == 0);
            v.mtc  = ($urandom_range(0, 2) == 0);
            v.mfc  = ($urandom_range(0, 1) == 0);
            v.rn   = regPick[$urandom_range(0, 9)];
            v.data = $urandom;
            if (v.rn == 5'd9 && $urandom_range(0, 1) == 1)
                v.data = mCompare - 32'($urandom_range(1, 4));
            if (v.rn == 5'd12 && $urandom_range(0, 1) == 1)
                v.data = v.data | 32'h1;
            v.exc  = ($urandom_range(0, 15) == 0);
            v.code = 5'($urandom_range(0, 15));
            v.pc   = $urandom;
            v.bd   = 1'($urandom);
            v.bad  = $urandom;
            v.rfe  = ($urandom_range(0, 9) == 0);
            v.ext  = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            v.expOut = 0; v.expDrv = 0; v.expInt = 0; v.expKm = 0;
            drive(v);
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cp0_move_unit.md
Name: cp0_move_unit

Overview:
- Coprocessor-0 side of the MTC0/MFC0 path; sits directly downstream of the datapath CP0 bus stager.
- Consumes the staged MEM-stage word on the CP0 bus for MTC0 writes and drives CP0 register contents back onto the bus for MFC0.
- Holds the system-control registers: BadVAddr, Count, Compare, Status, Cause, EPC.
- Handles the exception status push, RFE pop, timer compare and the interrupt request.

Parameters:
- RESET_COMPARE, 32'hFFFF_FFFF, Compare value after reset.
- NUM_EXT_INT, 5, number of external interrupt lines mapped to Cause[14:10].

Ports:
- Phi1  input  1  single clock; all state updates on its rising edge
- Reset_s1  input  1  synchronous, active-high reset
- Cp0Bus_s2m  input  32  MTC0 write data from the CP0 bus
- MvToCop0_s2m  input  1  MTC0 write strobe
- MvFromCop0_s2m  input  1  MFC0 read request
- Cp0RegNum_s2m  input  5  CP0 register number for read/write
- Cp0BusOut_v2m  output  32  MFC0 read data
- cp0BusDrv_s2m  output  1  read data valid / bus drive enable
- Exception_s2m  input  1  exception commit pulse
- ExcCode_s2m  input  5  exception code
- ExcPC_s2m  input  32  restart PC of the faulting instruction
- ExcBD_s2m  input  1  fault occurred in a branch delay slot
- BadAddr_s2m  input  32  faulting virtual address
- Rfe_s2m  input  1  RFE commit pulse
- ExtInt_s1  input  NUM_EXT_INT  external interrupt levels
- IntReq_s1  output  1  interrupt request to the control unit
- KernelMode_s1  output  1  equals ~Status.KUc

Behaviour:
- Reset (Reset_s1 high at edge):
  - BadVAddr=0, Count=0, Compare=RESET_COMPARE.
  - Status=0: KUc=0 (kernel), IEc=0.
  - Cause=0, EPC=0.
  - Cp0BusOut_v2m=0, cp0BusDrv_s2m=0, IntReq_s1=0, KernelMode_s1=1.
  - Reset overrides every other input in the same cycle.
- Register map: 8 BadVAddr (read-only), 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
  - Writes to other numbers, and to 8, are ignored.
  - Reads of unmapped numbers return 0.
- Status layout:
  - [5:0] = {KUo,IEo,KUp,IEp,KUc,IEc}; [15:8] = IM.
  - Other bits read 0; writes to them are dropped.
- Cause layout:
  - [31] BD; [15] IP7 (timer, sticky); [14:10] IP6..IP2 (mirror ExtInt_s1 each cycle, not writable); [9:8] IP1..0 (software-writable); [6:2] ExcCode.
  - Other bits read 0.
- MTC0: when MvToCop0_s2m=1, the register is updated at the edge from Cp0Bus_s2m, masked as above.
- MFC0: request at edge N.
  - Cp0BusOut_v2m holds the register value sampled before any edge-N update (old value on same-cycle write).
  - cp0BusDrv_s2m=1 for exactly cycle N+1.
  - Back-to-back requests give back-to-back valid cycles.
  - When not driving, Cp0BusOut_v2m holds its last value.
- Count:
  - +1 every cycle, wrapping 32'hFFFF_FFFF -> 0.
  - An MTC0 to Count loads the written value with no increment that cycle.
  - Reads return the pre-increment value.
- Timer:
  - If the next Count value equals Compare, Cause[15] is set.
  - An MTC0 to Compare clears Cause[15] and writes Compare; Compare-clear wins over a same-cycle match.
- Exception (Exception_s2m=1):
  - EPC<=ExcPC_s2m; Cause.ExcCode<=ExcCode_s2m; Cause.BD<=ExcBD_s2m.
  - BadVAddr<=BadAddr_s2m only when ExcCode is 1..5.
  - Status[5:0]<={Status[3:0],2'b00}.
  - Takes priority over a same-cycle MTC0 (write dropped) and over Rfe. An MFC0 in the same cycle still completes.
- Rfe (Rfe_s2m=1, no exception): Status[3:0]<=Status[5:2]; Status[5:4] unchanged.
  - MTC0 to Status in the same cycle wins and the Rfe is ignored.
- IntReq_s1 is registered: IntReq_s1 <= Status.IEc & |(Cause[15:8] & Status.IM), evaluated on post-update values, so it responds one cycle after the cause.

Test Plan:
- Reset then MFC0 reg 11 -> cycle+1 drive=1, data=32'hFFFF_FFFF; MFC0 reg 12 -> 0; KernelMode_s1=1.
- MTC0 Status=32'hFFFF_FF3F then MFC0 12 -> 32'h0000_FF3F; same-cycle MTC0+MFC0 returns the old value 0.
- MTC0 Count=32'hFFFF_FFFE, Compare=32'h0000_0001 -> Count wraps through 0; Cause[15] sets on reaching 1; with IM7=IEc=1, IntReq_s1=1 the next cycle; MTC0 Compare clears it.
- Status[5:0]=6'b000011, Exception code 4, PC 32'h8000_0100, BadAddr 32'h1234_5673, BD=1 -> Status[5:0]=001100, EPC/BadVAddr loaded, Cause=32'h8000_0010; then Rfe -> Status[5:0]=000011.
- Exception code 8 with MTC0 EPC=32'hDEAD_BEEF in the same cycle -> EPC=ExcPC, BadVAddr unchanged.
- ExtInt_s1=5'b00001, IM2=1, IEc=0 -> no request; set IEc -> IntReq_s1=1 one cycle later; Reset_s1 mid-sequence -> all outputs back to reset values next cycle.
